// File: rtl/position_input_conditioner_pkg.sv
// Shared encodings and helpers for the riding-position input conditioner.
// Flag vector layout is {seat, bar, tops, hoods, drops}.
package position_pkg;

  localparam logic [1:0] HAND_DROPS = 2'd0;
  localparam logic [1:0] HAND_HOODS = 2'd1;
  localparam logic [1:0] HAND_TOPS  = 2'd2;
  localparam logic [1:0] HAND_BAR   = 2'd3;

  localparam int IDX_DROPS = 0;
  localparam int IDX_HOODS = 1;
  localparam int IDX_TOPS  = 2;
  localparam int IDX_BAR   = 3;
  localparam int IDX_SEAT  = 4;
  localparam int NUM_FLAGS = 5;

  typedef struct packed {
    logic       valid;
    logic [1:0] pos;
    logic       conflict;
  } hand_res_t;

  function automatic logic [2:0] popcount4(input logic [3:0] flags);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, flags[i]};
    end
    return cnt;
  endfunction

  // Highest-priority flag wins; an empty set encodes as drops with valid low.
  function automatic hand_res_t resolve_hand(input logic [3:0] flags);
    hand_res_t res;
    res.valid    = |flags;
    res.conflict = (popcount4(flags) >= 3'd2);
    if (flags[IDX_DROPS]) begin
      res.pos = HAND_DROPS;
    end else if (flags[IDX_HOODS]) begin
      res.pos = HAND_HOODS;
    end else if (flags[IDX_TOPS]) begin
      res.pos = HAND_TOPS;
    end else if (flags[IDX_BAR]) begin
      res.pos = HAND_BAR;
    end else begin
      res.pos = HAND_DROPS;
    end
    return res;
  endfunction

endpackage

// File: rtl/position_input_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser followed by a stability counter.
// The clean flag only moves after DEBOUNCE_CYCLES consecutive mismatching samples.
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1_r;
  logic          sync_q2_r;
  logic          clean_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic          clean_next_s;

  // Synchroniser flops for the asynchronous button input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1_r <= 1'b0;
      sync_q2_r <= 1'b0;
    end else begin
      sync_q1_r <= raw;
      sync_q2_r <= sync_q1_r;
    end
  end

  // Any return to the clean value restarts the stability count
  always_comb begin
    cnt_next_s   = cnt_r;
    clean_next_s = clean_r;
    if (sync_q2_r == clean_r) begin
      cnt_next_s = {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      clean_next_s = sync_q2_r;
      cnt_next_s   = {CW{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CW'(1);
    end
  end

  // Debounce counter and clean flag state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      clean_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_next_s;
      clean_r <= clean_next_s;
    end
  end

  assign clean = clean_r;

endmodule

// File: rtl/position_input_conditioner.sv
// Conditions five raw position buttons into clean flags, an encoded hand
// position with conflict/change indication, and a sustained-seat alarm.
module position_input_conditioner
  import position_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int SEAT_HOLD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drops_button,
  input  logic       hoods_button,
  input  logic       tops_button,
  input  logic       bar_button,
  input  logic       seat_button,
  output logic [4:0] pos_clean,
  output logic [1:0] hand_pos,
  output logic       hand_valid,
  output logic       hand_conflict,
  output logic       pos_change,
  output logic       seat_alarm
);

  localparam int SCW = $clog2(SEAT_HOLD_CYCLES + 1);
  localparam logic [SCW-1:0] SEAT_MAX = SCW'(SEAT_HOLD_CYCLES);

  logic [NUM_FLAGS-1:0] raw_s;
  logic [NUM_FLAGS-1:0] clean_s;

  hand_res_t      hand_next_s;
  logic           change_next_s;
  logic [1:0]     hand_pos_r;
  logic           hand_valid_r;
  logic           hand_conflict_r;
  logic           pos_change_r;

  logic [SCW-1:0] seat_cnt_r;
  logic [SCW-1:0] seat_cnt_next_s;
  logic           seat_alarm_r;

  assign raw_s = {seat_button, bar_button, tops_button, hoods_button, drops_button};

  for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_s[g]),
      .clean (clean_s[g])
    );
  end

  // Resolve hand flags and detect a change against the registered value
  always_comb begin
    hand_next_s   = resolve_hand(clean_s[IDX_BAR:IDX_DROPS]);
    change_next_s = ({hand_next_s.valid, hand_next_s.pos} != {hand_valid_r, hand_pos_r});
  end

  // Hand resolver output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hand_pos_r      <= HAND_DROPS;
      hand_valid_r    <= 1'b0;
      hand_conflict_r <= 1'b0;
      pos_change_r    <= 1'b0;
    end else begin
      hand_pos_r      <= hand_next_s.pos;
      hand_valid_r    <= hand_next_s.valid;
      hand_conflict_r <= hand_next_s.conflict;
      pos_change_r    <= change_next_s;
    end
  end

  // Seat hold counter saturates so the alarm stays up while seated
  always_comb begin
    seat_cnt_next_s = seat_cnt_r;
    if (!clean_s[IDX_SEAT]) begin
      seat_cnt_next_s = {SCW{1'b0}};
    end else if (seat_cnt_r == SEAT_MAX) begin
      seat_cnt_next_s = SEAT_MAX;
    end else begin
      seat_cnt_next_s = seat_cnt_r + SCW'(1);
    end
  end

  // Seat counter and alarm registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seat_cnt_r   <= {SCW{1'b0}};
      seat_alarm_r <= 1'b0;
    end else begin
      seat_cnt_r   <= seat_cnt_next_s;
      seat_alarm_r <= (seat_cnt_next_s == SEAT_MAX);
    end
  end

  assign pos_clean     = clean_s;
  assign hand_pos      = hand_pos_r;
  assign hand_valid    = hand_valid_r;
  assign hand_conflict = hand_conflict_r;
  assign pos_change    = pos_change_r;
  assign seat_alarm    = seat_alarm_r;

endmodule

// File: tb/tb_position_input_conditioner.sv
// Directed bench for position_input_conditioner with DEBOUNCE_CYCLES=4, SEAT_HOLD_CYCLES=8.
module tb_position_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic       drops_button;
  logic       hoods_button;
  logic       tops_button;
  logic       bar_button;
  logic       seat_button;
  logic [4:0] pos_clean;
  logic [1:0] hand_pos;
  logic       hand_valid;
  logic       hand_conflict;
  logic       pos_change;
  logic       seat_alarm;

  int errors;
  int checks;

  position_input_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .SEAT_HOLD_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .drops_button  (drops_button),
    .hoods_button  (hoods_button),
    .tops_button   (tops_button),
    .bar_button    (bar_button),
    .seat_button   (seat_button),
    .pos_clean     (pos_clean),
    .hand_pos      (hand_pos),
    .hand_valid    (hand_valid),
    .hand_conflict (hand_conflict),
    .pos_change    (pos_change),
    .seat_alarm    (seat_alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pos_clean"}, 32'(pos_clean), 32'h0);
    chk({tag, "_hand_pos"}, 32'(hand_pos), 32'h0);
    chk({tag, "_hand_valid"}, 32'(hand_valid), 32'h0);
    chk({tag, "_hand_conflict"}, 32'(hand_conflict), 32'h0);
    chk({tag, "_pos_change"}, 32'(pos_change), 32'h0);
    chk({tag, "_seat_alarm"}, 32'(seat_alarm), 32'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // 1: reset with all buttons pressed, then release
    rst_n        = 1'b0;
    drops_button = 1'b1;
    hoods_button = 1'b1;
    tops_button  = 1'b1;
    bar_button   = 1'b1;
    seat_button  = 1'b1;
    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(5);
    chk("lat_edge5_pos_clean", 32'(pos_clean), 32'h00);
    tick(1);
    chk("lat_edge6_pos_clean", 32'(pos_clean), 32'h1F);
    chk("lat_edge6_hand_valid", 32'(hand_valid), 32'h0);
    chk("lat_edge6_pos_change", 32'(pos_change), 32'h0);
    tick(1);
    chk("lat_edge7_hand_pos", 32'(hand_pos), 32'h0);
    chk("lat_edge7_hand_valid", 32'(hand_valid), 32'h1);
    chk("lat_edge7_conflict", 32'(hand_conflict), 32'h1);
    chk("lat_edge7_pos_change", 32'(pos_change), 32'h1);
    tick(1);
    chk("lat_edge8_pos_change", 32'(pos_change), 32'h0);
    drops_button = 1'b0;
    hoods_button = 1'b0;
    tops_button  = 1'b0;
    bar_button   = 1'b0;
    seat_button  = 1'b0;
    tick(14);
    chk("idle_pos_clean", 32'(pos_clean), 32'h00);
    chk("idle_hand_valid", 32'(hand_valid), 32'h0);
    chk("idle_seat_alarm", 32'(seat_alarm), 32'h0);

    // 2: hoods bounces high-high-low for 30 cycles, then holds high
    for (int i = 0; i < 30; i++) begin
      hoods_button = ((i % 3) != 2);
      tick(1);
      chk("bounce_quiet", 32'(pos_clean), 32'h00);
    end
    hoods_button = 1'b1;
    tick(5);
    chk("bounce_edge5", 32'(pos_clean), 32'h00);
    tick(1);
    chk("bounce_edge6", 32'(pos_clean), 32'h02);
    tick(1);
    chk("hoods_hand_pos", 32'(hand_pos), 32'h1);
    chk("hoods_pos_change", 32'(pos_change), 32'h1);

    // hoods off and tops on together: both settle on the same edge
    hoods_button = 1'b0;
    tops_button  = 1'b1;
    tick(6);
    chk("swap_pos_clean", 32'(pos_clean), 32'h04);
    tick(1);
    chk("tops_hand_pos", 32'(hand_pos), 32'h2);
    chk("tops_conflict", 32'(hand_conflict), 32'h0);
    chk("tops_pos_change", 32'(pos_change), 32'h1);
    tick(1);
    chk("tops_pos_change_end", 32'(pos_change), 32'h0);

    // 3: drops over tops, then release drops
    drops_button = 1'b1;
    tick(6);
    chk("drops_pos_clean", 32'(pos_clean), 32'h05);
    chk("drops_hand_pos_pre", 32'(hand_pos), 32'h2);
    tick(1);
    chk("drops_hand_pos", 32'(hand_pos), 32'h0);
    chk("drops_conflict", 32'(hand_conflict), 32'h1);
    chk("drops_pos_change", 32'(pos_change), 32'h1);
    tick(1);
    chk("drops_pos_change_end", 32'(pos_change), 32'h0);
    chk("drops_hand_pos_hold", 32'(hand_pos), 32'h0);
    drops_button = 1'b0;
    tick(6);
    chk("undrop_pos_clean", 32'(pos_clean), 32'h04);
    tick(1);
    chk("undrop_hand_pos", 32'(hand_pos), 32'h2);
    chk("undrop_conflict", 32'(hand_conflict), 32'h0);
    chk("undrop_pos_change", 32'(pos_change), 32'h1);
    tick(1);
    chk("undrop_pos_change_end", 32'(pos_change), 32'h0);

    // 4: seat alarm after 8 clean cycles, clears one edge after clean falls
    seat_button = 1'b1;
    tick(6);
    chk("seat_pos_clean", 32'(pos_clean), 32'h14);
    tick(7);
    chk("seat_alarm_edge7", 32'(seat_alarm), 32'h0);
    tick(1);
    chk("seat_alarm_edge8", 32'(seat_alarm), 32'h1);
    tick(3);
    chk("seat_alarm_hold", 32'(seat_alarm), 32'h1);
    seat_button = 1'b0;
    tick(6);
    chk("seat_fall_pos_clean", 32'(pos_clean), 32'h04);
    chk("seat_fall_alarm_same", 32'(seat_alarm), 32'h1);
    tick(1);
    chk("seat_fall_alarm_next", 32'(seat_alarm), 32'h0);

    // seat clean-high for only 5 cycles
    seat_button = 1'b1;
    tick(5);
    seat_button = 1'b0;
    tick(1);
    chk("short_seat_pos_clean", 32'(pos_clean), 32'h14);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("short_seat_no_alarm", 32'(seat_alarm), 32'h0);
    end
    chk("short_seat_released", 32'(pos_clean), 32'h04);

    // 5: reset while seat alarm is up and hoods is mid-debounce
    seat_button = 1'b1;
    tick(6);
    chk("rst5_seat_clean", 32'(pos_clean), 32'h14);
    tick(4);
    hoods_button = 1'b1;
    tick(4);
    chk("rst5_alarm_up", 32'(seat_alarm), 32'h1);
    chk("rst5_hoods_pending", 32'(pos_clean), 32'h14);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(5);
    chk("rst5_edge5_pos_clean", 32'(pos_clean), 32'h00);
    tick(1);
    chk("rst5_edge6_pos_clean", 32'(pos_clean), 32'h16);
    chk("rst5_edge6_alarm", 32'(seat_alarm), 32'h0);
    tick(1);
    chk("rst5_edge7_hand_pos", 32'(hand_pos), 32'h1);
    chk("rst5_edge7_hand_valid", 32'(hand_valid), 32'h1);
    chk("rst5_edge7_conflict", 32'(hand_conflict), 32'h1);
    chk("rst5_edge7_pos_change", 32'(pos_change), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
